// File: rtl/inv_key_schedule_pkg.sv
// Shared AES constants, types and GF(2^8) helpers for the inverse key schedule.
package inv_key_schedule_pkg;

   localparam int DATA_WIDTH     = 128;
   localparam int NUM_ROUNDS_128 = 10;

   typedef enum logic [1:0] {IDLE, EXPAND, DONE} rk_state_t;

   // Round constants for rounds 1..10, stored at index round-1.
   localparam logic [0:9][7:0] RCON = {
      8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
   };

   // Forward AES S-box, entry 0 first.
   localparam logic [0:255][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   // Multiply by x (0x02) modulo the AES polynomial.
   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   // General GF(2^8) multiply; with a constant b this folds to a few XORs.
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] t;
      p = '0;
      t = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ t;
         t = xtime(t);
      end
      return p;
   endfunction

endpackage

// File: rtl/inv_key_schedule_key_expand_step.sv
// One AES-128 key expansion round (combinational) plus its S-box lookup.
module aes_sbox
   import inv_key_schedule_pkg::*;
(
   input  logic [7:0] din,
   output logic [7:0] dout
);
   assign dout = SBOX[din];
endmodule

module key_expand_step
   import inv_key_schedule_pkg::*;
(
   input  logic [DATA_WIDTH-1:0] prev_key,
   input  logic [3:0]            round,
   output logic [DATA_WIDTH-1:0] next_key
);
   logic [31:0] p0, p1, p2, p3;
   logic [31:0] rot, sub;
   logic [31:0] w0, w1, w2, w3;
   logic [7:0]  rcon;

   assign {p0, p1, p2, p3} = prev_key;
   assign rot = {p3[23:0], p3[31:24]};

   for (genvar i = 0; i < 4; i++) begin : g_sbox
      aes_sbox u_sbox (.din(rot[8*i +: 8]), .dout(sub[8*i +: 8]));
   end

   // Rounds outside 1..10 never reach the store; give them a harmless zero.
   always_comb begin
      rcon = 8'h00;
      if (round >= 4'd1 && round <= 4'd10) rcon = RCON[round - 4'd1];
   end

   assign w0 = p0 ^ sub ^ {rcon, 24'h0};
   assign w1 = w0 ^ p1;
   assign w2 = w1 ^ p2;
   assign w3 = w2 ^ p3;
   assign next_key = {w0, w1, w2, w3};
endmodule

// File: rtl/inv_key_schedule.sv
// Iterative AES-128 key expander and round-key store for the decipher path.
// Optional macro INV_KEY_MIXCOL_EN: reads of rk1..rk9 return InvMixColumns(rk)
// for the equivalent inverse cipher; rk0 and rk10 are always returned raw.
module inv_key_schedule
   import inv_key_schedule_pkg::*;
#(
   parameter int NUM_ROUNDS = 10,
   parameter int IDX_WIDTH  = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] key_in,
   input  logic                  key_valid,
   output logic                  key_ready,
   output logic                  keys_ready,
   input  logic                  rd_en,
   input  logic [IDX_WIDTH-1:0]  rd_idx,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid,
   output logic                  rd_err
);

   if (NUM_ROUNDS != NUM_ROUNDS_128) begin : g_bad_rounds
      $error("inv_key_schedule: only NUM_ROUNDS = 10 (AES-128) is supported");
   end

   rk_state_t             state, next_state;
   logic [3:0]            round;
   logic [DATA_WIDTH-1:0] rk [0:NUM_ROUNDS_128];
   logic [DATA_WIDTH-1:0] prev_key, next_key, rd_word;
   logic                  accept, rd_legal;

   assign accept = key_valid && key_ready;

   // Previous round key feeding the expansion step; round is 1..10 in EXPAND.
   always_comb begin
      prev_key = '0;
      if (round >= 4'd1 && round <= 4'd10) prev_key = rk[round - 4'd1];
   end

   key_expand_step u_step (.prev_key(prev_key), .round(round), .next_key(next_key));

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   // Next state: accept moves to EXPAND, writing rk10 finishes.
   always_comb begin
      next_state = state;
      case (state)
         IDLE, DONE: if (accept) next_state = EXPAND;
         EXPAND:     if (round == 4'(NUM_ROUNDS_128)) next_state = DONE;
         default:    next_state = IDLE;
      endcase
   end

   // Handshake outputs decoded from state.
   always_comb begin
      key_ready  = (state != EXPAND);
      keys_ready = (state == DONE);
   end

   // Key store and round counter: load rk0 on accept, one round per edge after.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i <= NUM_ROUNDS_128; i++) rk[i] <= '0;
         round <= '0;
      end else if (accept) begin
         rk[0] <= key_in;
         round <= 4'd1;
      end else if (state == EXPAND) begin
         rk[round] <= next_key;
         round     <= round + 4'd1;
      end
   end

`ifdef INV_KEY_MIXCOL_EN
   // Per-column InvMixColumns; byte 0 of each column is its MSB.
   function automatic logic [DATA_WIDTH-1:0] inv_mix_columns(input logic [DATA_WIDTH-1:0] s);
      logic [DATA_WIDTH-1:0] o;
      logic [7:0] a0, a1, a2, a3;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         {a0, a1, a2, a3} = s[DATA_WIDTH-1-32*c -: 32];
         o[DATA_WIDTH-1-32*c -: 32] = {
            gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
            gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
            gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
            gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
      end
      return o;
   endfunction
`endif

   // Read select; legality uses the pre-edge state so a same-edge accept returns old keys.
   always_comb begin
      rd_legal = (state == DONE) && (rd_idx <= IDX_WIDTH'(NUM_ROUNDS_128));
      rd_word  = '0;
      if (rd_legal) rd_word = rk[rd_idx];
`ifdef INV_KEY_MIXCOL_EN
      if (rd_legal && rd_idx >= IDX_WIDTH'(1) && rd_idx <= IDX_WIDTH'(NUM_ROUNDS_128 - 1))
         rd_word = inv_mix_columns(rd_word);
`endif
   end

   // Registered read port: one result per rd_en cycle, cleared when idle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_data  <= '0;
         rd_valid <= 1'b0;
         rd_err   <= 1'b0;
      end else begin
         rd_valid <= rd_en;
         rd_err   <= rd_en && !rd_legal;
         rd_data  <= rd_en ? rd_word : '0;
      end
   end

endmodule

// File: tb/tb_inv_key_schedule.sv
// Self-checking bench for inv_key_schedule against an independent AES key-schedule model.
module tb_inv_key_schedule;

   logic         clk = 1'b0;
   logic         rst;
   logic [127:0] key_in;
   logic         key_valid, key_ready, keys_ready;
   logic         rd_en;
   logic [3:0]   rd_idx;
   logic [127:0] rd_data;
   logic         rd_valid, rd_err;

   int checks = 0;
   int errors = 0;

   logic [7:0]   sb [0:255];
   logic [127:0] exp_rk [0:10];

   always #5 clk = ~clk;

   inv_key_schedule #(.NUM_ROUNDS(10), .IDX_WIDTH(4)) dut (
      .clk(clk), .rst(rst), .key_in(key_in), .key_valid(key_valid),
      .key_ready(key_ready), .keys_ready(keys_ready), .rd_en(rd_en),
      .rd_idx(rd_idx), .rd_data(rd_data), .rd_valid(rd_valid), .rd_err(rd_err));

   // Carry-less product followed by reduction by x^8+x^4+x^3+x+1.
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [15:0] p;
      p = '0;
      for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
      for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
      return p[7:0];
   endfunction

   // S-box from first principles: multiplicative inverse then affine map.
   task automatic build_sbox();
      logic [7:0] inv, b;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         b = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
             ^ {inv[3:0], inv[7:4]} ^ 8'h63;
         sb[x] = b;
      end
   endtask

   // FIPS-197 word-oriented expansion into 11 round keys.
   task automatic model_expand(input logic [127:0] k);
      logic [31:0] w [0:43];
      logic [31:0] t;
      logic [7:0]  rc;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t  = {t[23:0], t[31:24]};
            t  = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
            rc = gmul(rc, 8'h02);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   // InvMixColumns as a matrix product over each 4-byte column.
   function automatic logic [127:0] inv_mix(input logic [127:0] s);
      logic [7:0]   m [0:3][0:3];
      logic [7:0]   acc;
      logic [127:0] o;
      m = '{'{8'h0e, 8'h0b, 8'h0d, 8'h09}, '{8'h09, 8'h0e, 8'h0b, 8'h0d},
            '{8'h0d, 8'h09, 8'h0e, 8'h0b}, '{8'h0b, 8'h0d, 8'h09, 8'h0e}};
      o = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++) begin
            acc = 8'h00;
            for (int k = 0; k < 4; k++) acc = acc ^ gmul(m[r][k], s[127-8*(4*c+k) -: 8]);
            o[127-8*(4*c+r) -: 8] = acc;
         end
      return o;
   endfunction

   // What a legal read of idx should return for a given raw round key.
   function automatic logic [127:0] adj(input int idx, input logic [127:0] raw);
      logic [127:0] v;
      v = raw;
`ifdef INV_KEY_MIXCOL_EN
      if (idx >= 1 && idx <= 9) v = inv_mix(raw);
`endif
      return v;
   endfunction

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Count edges until keys_ready, bounded.
   task automatic wait_kr(output int n);
      n = 0;
      while (!keys_ready && n < 20) begin
         tick();
         n++;
      end
   endtask

   localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

   initial begin
      int n, idx;
      logic [127:0] k1, k2, k3, old10;

      rst = 1'b1; key_in = '0; key_valid = 1'b0; rd_en = 1'b0; rd_idx = '0;
      build_sbox();
      #12;
      chk("rst_key_ready", key_ready, 1);
      chk("rst_keys_ready", keys_ready, 0);
      chk("rst_rd_valid", rd_valid, 0);
      chk("rst_rd_err", rd_err, 0);
      chk("rst_rd_data", rd_data, 0);
      rst = 1'b0;

      // FIPS-197 key: latency and known round keys.
      model_expand(FIPS_KEY);
      key_in = FIPS_KEY; key_valid = 1'b1;
      tick();
      key_valid = 1'b0;
      chk("acc_key_ready", key_ready, 0);
      chk("acc_keys_ready", keys_ready, 0);
      wait_kr(n);
      chk("fips_latency", n, 10);
      chk("done_key_ready", key_ready, 1);
      rd_en = 1'b1;
      rd_idx = 4'd1;  tick();
      chk("fips_rk1", rd_data, adj(1, 128'ha0fafe1788542cb123a339392a6c7605));
      chk("fips_rk1_valid", {rd_valid, rd_err}, 2'b10);
      rd_idx = 4'd10; tick();
      chk("fips_rk10", rd_data, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      rd_idx = 4'd0;  tick();
      chk("fips_rk0", rd_data, FIPS_KEY);
      rd_idx = 4'd5;  tick();
      chk("fips_rk5_model", rd_data, adj(5, exp_rk[5]));
      rd_en = 1'b0;
      tick();
      chk("rd_valid_drop", rd_valid, 0);

      // All-zero key, reverse sweep on consecutive cycles.
      model_expand('0);
      key_in = '0; key_valid = 1'b1;
      tick();
      key_valid = 1'b0;
      wait_kr(n);
      chk("zero_latency", n, 10);
      rd_en = 1'b1;
      for (int i = 10; i >= 0; i--) begin
         rd_idx = 4'(i);
         tick();
         chk("sweep_vld_err", {rd_valid, rd_err}, 2'b10);
         chk("sweep_data", rd_data, adj(i, exp_rk[i]));
         if (i == 10) chk("zero_rk10", rd_data, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
      end
      rd_en = 1'b0;
      tick();
      chk("sweep_end", rd_valid, 0);

      // Random key; illegal read and ignored key during EXPAND.
      k1 = {$urandom, $urandom, $urandom, $urandom};
      k2 = {$urandom, $urandom, $urandom, $urandom};
      model_expand(k1);
      key_in = k1; key_valid = 1'b1;
      tick();
      key_valid = 1'b0;
      tick(); tick();
      rd_en = 1'b1; rd_idx = 4'd3; key_in = k2; key_valid = 1'b1;
      tick();
      rd_en = 1'b0; key_valid = 1'b0;
      chk("exp_rd_vld_err", {rd_valid, rd_err}, 2'b11);
      chk("exp_rd_data", rd_data, 0);
      chk("exp_key_ready", key_ready, 0);
      wait_kr(n);
      chk("exp_remaining", n, 7);
      rd_en = 1'b1;
      for (int i = 0; i < 16; i++) begin
         idx = (i < 12) ? int'($urandom_range(0, 15)) : 11 + (i - 12);
         rd_idx = 4'(idx);
         tick();
         chk("rnd_err", {rd_valid, rd_err}, {1'b1, idx > 10});
         chk("rnd_data", rd_data, (idx > 10) ? 128'h0 : adj(idx, exp_rk[idx]));
      end

      // New key accepted in DONE with same-edge read of rk10.
      k3 = {$urandom, $urandom, $urandom, $urandom};
      old10 = exp_rk[10];
      rd_idx = 4'd10; key_in = k3; key_valid = 1'b1;
      tick();
      rd_en = 1'b0; key_valid = 1'b0;
      chk("swap_old_rk10", rd_data, old10);
      chk("swap_err", {rd_valid, rd_err}, 2'b10);
      chk("swap_keys_ready", keys_ready, 0);
      model_expand(k3);
      wait_kr(n);
      chk("swap_latency", n, 10);
      rd_en = 1'b1; rd_idx = 4'd7; tick();
      chk("swap_new_rk7", rd_data, adj(7, exp_rk[7]));
      rd_idx = 4'd10; tick();
      chk("swap_new_rk10", rd_data, exp_rk[10]);
      rd_en = 1'b0;

      // Asynchronous reset in the middle of expansion.
      key_in = FIPS_KEY; key_valid = 1'b1;
      tick();
      key_valid = 1'b0;
      repeat (4) tick();
      rd_en = 1'b1; rd_idx = 4'd0;
      tick();
      rd_en = 1'b0;
      chk("pre_rst_read", {rd_valid, rd_err}, 2'b11);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_outs", {key_ready, keys_ready, rd_valid, rd_err}, 4'b1000);
      chk("async_rst_data", rd_data, 0);
      #2 rst = 1'b0;
      rd_en = 1'b1; rd_idx = 4'd0;
      tick();
      rd_en = 1'b0;
      chk("post_rst_read", {rd_valid, rd_err, keys_ready}, 3'b110);
      chk("post_rst_data", rd_data, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
